multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 30 +++
 rtl/perf_counter.sv | 19 +
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states,
// instruction classes and class width.
package multicycle_ctrl_pkg;

    localparam int CLS_W = 3;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [CLS_W-1:0] {
        C_ALU     = 3'd0,
        C_LOAD    = 3'd1,
        C_STORE   = 3'd2,
        C_BR_COND = 3'd3,
        C_B       = 3'd4,
        C_LINK    = 3'd5
    } cls_t;

    // Branches and invalid classes complete in ID.
    function automatic logic done_in_id(input logic [CLS_W-1:0] c);
        return !(c == C_ALU || c == C_LOAD || c == C_STORE
                 || c == C_LINK);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running performance counter with synchronous clear.
// Ports: clk, clear (sync, wins over en), en, count[W-1:0].
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EXE/MEM/WB) with memory-wait
// timeout flag and retire/cycle performance counters.
// Ports: clk, reset (sync, active-high), inst_class, imem_ready,
//   dmem_ready in; state, imem_req, ir_we, pc_we, dmem_req, dmem_we,
//   rf_we, retire, retired_cnt, cycle_cnt, bus_err out.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CLS_W-1:0] inst_class,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             bus_err
);

    localparam int WAIT_W =
        (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [CLS_W-1:0] cls_q;
    logic [CLS_W-1:0] cls_d;

    logic imem_req_c;
    logic ir_we_c;
    logic pc_we_c;
    logic dmem_req_c;
    logic dmem_we_c;
    logic rf_we_c;
    logic retire_c;

    logic [WAIT_W-1:0] wait_q;
    logic              bus_err_q;
    logic              waiting;

    logic [CNT_W-1:0] ret_q;
    logic [CNT_W-1:0] cyc_q;

    // The IR is latched at the end of IF, so its decoded class is
    // stable throughout ID; ID decides from it and captures it.
    assign cls_d = (state_q == S_ID) ? inst_class : cls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            cls_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        retire_c   = 1'b0;
        case (state_q)
            S_IF: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (done_in_id(cls_d)) begin
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    state_d  = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (cls_q == C_LOAD || cls_q == C_STORE)
                    state_d = S_MEM;
                else if (cls_q == C_ALU || cls_q == C_LINK)
                    state_d = S_WB;
                else
                    state_d = S_IF;
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_q == C_STORE);
                if (dmem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // A stall cycle never changes state, so clearing whenever we are
    // not stalled also covers the clear-on-state-change case.
    assign waiting = (state_q == S_IF  && !imem_ready)
                  || (state_q == S_MEM && !dmem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (!waiting)
                wait_q <= '0;
            else if (wait_q != WAIT_MAX)
                wait_q <= wait_q + 1'b1;
            // Set on the same edge the counter reaches the limit.
            if (waiting && wait_q >= WAIT_MAX - 1'b1)
                bus_err_q <= 1'b1;
        end
    end

    perf_counter #(.W(CNT_W)) u_ret_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (retire_c),
        .count (ret_q)
    );

    perf_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (1'b1),
        .count (cyc_q)
    );

    // Reset masks every output, so an aborted instruction has no
    // side effects in the reset cycle itself.
    assign state       = reset ? S_IF : state_q;
    assign imem_req    = imem_req_c & ~reset;
    assign ir_we       = ir_we_c & ~reset;
    assign pc_we       = pc_we_c & ~reset;
    assign dmem_req    = dmem_req_c & ~reset;
    assign dmem_we     = dmem_we_c & ~reset;
    assign rf_we       = rf_we_c & ~reset;
    assign retire      = retire_c & ~reset;
    assign retired_cnt = reset ? '0 : ret_q;
    assign cycle_cnt   = reset ? '0 : cyc_q;
    assign bus_err     = bus_err_q & ~reset;

endmodule
